// File: rtl/maxpool_2x2_engine.sv
// 2x2 stride-2 signed max pooling over CH maps of IN_DIM x IN_DIM words.
// Source words are read through SRAM port A; pooled words are written back through port B.
module maxpool_2x2_engine #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 16,
    parameter int CH       = 6,
    parameter int IN_DIM   = 28,
    parameter int SRC_BASE = 0,
    parameter int DST_BASE = 4704
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] sram_aa,
    output logic              sram_cena,
    input  logic [DATA_W-1:0] sram_qa,
    output logic [ADDR_W-1:0] sram_ab,
    output logic              sram_cenb,
    output logic              sram_wenb,
    output logic [DATA_W-1:0] sram_db
);

    localparam int OUT_DIM = IN_DIM / 2;
    localparam int QW = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
    localparam int CW = (CH > 1) ? $clog2(CH) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]               state;
    logic [QW-1:0]            q_cnt;
    logic [QW-1:0]            r_cnt;
    logic [CW-1:0]            c_cnt;
    logic [1:0]               k_p0;
    logic [1:0]               k_p1;
    logic                     vld_p1;
    logic [ADDR_W-1:0]        win_addr;
    logic [ADDR_W-1:0]        win_next;
    logic [ADDR_W-1:0]        rd_off_nxt;
    logic [ADDR_W-1:0]        wr_cnt;
    logic                     q_last;
    logic                     r_last;
    logic                     last_win;
    logic signed [DATA_W-1:0] qa_s;
    logic signed [DATA_W-1:0] max_p1;

    function automatic logic signed [DATA_W-1:0] smax(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        return (b > a) ? b : a;
    endfunction

    assign qa_s = sram_qa;

    always_comb begin
        q_last   = (q_cnt == QW'(OUT_DIM - 1));
        r_last   = (r_cnt == QW'(OUT_DIM - 1));
        last_win = q_last && r_last && (c_cnt == CW'(CH - 1));
        // End of a row pair jumps over the odd source row; channels are contiguous.
        win_next = q_last ? win_addr + ADDR_W'(IN_DIM + 2) : win_addr + ADDR_W'(2);
        case (k_p0)
            2'd0:    rd_off_nxt = ADDR_W'(1);
            2'd1:    rd_off_nxt = ADDR_W'(IN_DIM);
            default: rd_off_nxt = ADDR_W'(IN_DIM + 1);
        endcase
    end

    // Stage p0: read issue, stage p1: data return, then single-cycle write on port B
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            sram_aa   <= '0;
            sram_cena <= 1'b1;
            sram_ab   <= '0;
            sram_cenb <= 1'b1;
            sram_wenb <= 1'b1;
            sram_db   <= '0;
            q_cnt     <= '0;
            r_cnt     <= '0;
            c_cnt     <= '0;
            k_p0      <= '0;
            k_p1      <= '0;
            vld_p1    <= 1'b0;
            win_addr  <= '0;
            wr_cnt    <= '0;
        end else begin
            vld_p1 <= (state == S_RUN);
            k_p1   <= k_p0;

            if (vld_p1 && (k_p1 == 2'd3)) begin
                sram_cenb <= 1'b0;
                sram_wenb <= 1'b0;
                sram_db   <= smax(max_p1, qa_s);
                sram_ab   <= ADDR_W'(DST_BASE) + wr_cnt;
                wr_cnt    <= wr_cnt + ADDR_W'(1);
            end else begin
                sram_cenb <= 1'b1;
                sram_wenb <= 1'b1;
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state     <= S_RUN;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        sram_cena <= 1'b0;
                        sram_aa   <= ADDR_W'(SRC_BASE);
                        win_addr  <= ADDR_W'(SRC_BASE);
                        q_cnt     <= '0;
                        r_cnt     <= '0;
                        c_cnt     <= '0;
                        k_p0      <= '0;
                        wr_cnt    <= '0;
                    end
                end
                S_RUN: begin
                    if (k_p0 == 2'd3) begin
                        k_p0 <= '0;
                        if (last_win) begin
                            state     <= S_DRAIN;
                            sram_cena <= 1'b1;
                        end else begin
                            sram_aa  <= win_next;
                            win_addr <= win_next;
                            if (q_last) begin
                                q_cnt <= '0;
                                if (r_last) begin
                                    r_cnt <= '0;
                                    c_cnt <= c_cnt + CW'(1);
                                end else begin
                                    r_cnt <= r_cnt + QW'(1);
                                end
                            end else begin
                                q_cnt <= q_cnt + QW'(1);
                            end
                        end
                    end else begin
                        k_p0    <= k_p0 + 2'd1;
                        sram_aa <= win_addr + rd_off_nxt;
                    end
                end
                S_DRAIN: begin
                    if (!sram_cenb) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (vld_p1) begin
            max_p1 <= (k_p1 == 2'd0) ? qa_s : smax(max_p1, qa_s);
        end
    end

endmodule

// File: tb/tb_maxpool_2x2_engine.sv
// Bench for maxpool_2x2_engine: SRAM model, per-window expectation scoreboard,
// cycle-exact port/timing checks, stray start, mid-run reset and restart.
module tb_maxpool_2x2_engine;

    localparam int NSRC    = 4704;
    localparam int DST     = 4704;
    localparam int NW      = 1176;
    localparam int T_LASTR = 4703;
    localparam int T_DONE  = 4706;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        busy, done;
    logic [15:0] sram_aa, sram_ab;
    logic        sram_cena, sram_cenb, sram_wenb;
    logic [31:0] sram_qa, sram_db;

    always #5 clk = ~clk;

    maxpool_2x2_engine #(
        .DATA_W(32), .ADDR_W(16), .CH(6), .IN_DIM(28), .SRC_BASE(0), .DST_BASE(4704)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .sram_aa(sram_aa), .sram_cena(sram_cena), .sram_qa(sram_qa),
        .sram_ab(sram_ab), .sram_cenb(sram_cenb), .sram_wenb(sram_wenb), .sram_db(sram_db)
    );

    logic [31:0] mem [0:65535];
    logic [31:0] img [0:5879];
    logic        load = 1'b0;

    always @(posedge clk) begin
        if (load) for (int i = 0; i < 5880; i++) mem[i] <= img[i];
        if (!sram_cena) sram_qa <= mem[sram_aa];
        if (!sram_cenb && !sram_wenb) mem[sram_ab] <= sram_db;
    end

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] data;
    } exp_t;

    typedef struct packed {
        logic [31:0] v0, v1, v2, v3, m;
    } vec_t;

    exp_t        exp_q[$];
    logic [31:0] exp_img [0:NW-1];
    vec_t        tbl [0:9];
    int          total, bad;

    task automatic chk(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic int src_addr(input int w, input int k);
        int c, r, q;
        c = w / 196;
        r = (w % 196) / 14;
        q = w % 14;
        return c * 784 + (2 * r + k / 2) * 28 + 2 * q + k % 2;
    endfunction

    function automatic logic [31:0] vec_word(input vec_t t, input int k);
        case (k)
            0: return t.v0;
            1: return t.v1;
            2: return t.v2;
            default: return t.v3;
        endcase
    endfunction

    function automatic logic [31:0] smax4(input logic [31:0] a, b, c, d);
        logic signed [31:0] m;
        m = a;
        if ($signed(b) > m) m = b;
        if ($signed(c) > m) m = c;
        if ($signed(d) > m) m = d;
        return m;
    endfunction

    task automatic init_dst();
        for (int i = NSRC; i < 5880; i++) img[i] = 32'hDEADBEEF;
    endtask

    task automatic prep_ramp();
        int c, r, q;
        for (int i = 0; i < NSRC; i++) img[i] = i;
        for (int w = 0; w < NW; w++) begin
            c = w / 196; r = (w % 196) / 14; q = w % 14;
            exp_img[w] = c * 784 + (2 * r + 1) * 28 + 2 * q + 1;
        end
        init_dst();
    endtask

    task automatic prep_table();
        for (int w = 0; w < NW; w++) begin
            for (int k = 0; k < 4; k++) img[src_addr(w, k)] = vec_word(tbl[w % 10], k);
            exp_img[w] = tbl[w % 10].m;
        end
        init_dst();
    endtask

    task automatic prep_rand();
        for (int i = 0; i < NSRC; i++) img[i] = $urandom;
        for (int w = 0; w < NW; w++)
            exp_img[w] = smax4(img[src_addr(w, 0)], img[src_addr(w, 1)],
                               img[src_addr(w, 2)], img[src_addr(w, 3)]);
        init_dst();
    endtask

    task automatic push_exp();
        exp_t e;
        exp_q.delete();
        for (int w = 0; w < NW; w++) begin
            e.addr = 16'(DST + w);
            e.data = exp_img[w];
            exp_q.push_back(e);
        end
    endtask

    task automatic load_mem();
        @(posedge clk); #1 load = 1'b1;
        @(posedge clk); #1 load = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_cena"}, sram_cena, 1);
        chk({tag, "_cenb"}, sram_cenb, 1);
        chk({tag, "_wenb"}, sram_wenb, 1);
        chk({tag, "_aa"}, sram_aa, 0);
        chk({tag, "_ab"}, sram_ab, 0);
        chk({tag, "_db"}, sram_db, 0);
    endtask

    task automatic run_pass(input string tag, input int stray_at, input int rst_at);
        int   done_idx, wr_seen, cena_err, aa_err, bd_err, pb_err, wt_err, rg_err, extra, diffs;
        exp_t e;
        done_idx = -1;
        wr_seen = 0; cena_err = 0; aa_err = 0; bd_err = 0;
        pb_err = 0; wt_err = 0; rg_err = 0; extra = 0; diffs = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int idx = 0; idx < T_DONE + 6; idx++) begin
            @(negedge clk);
            if (idx == rst_at) begin
                rst = 1'b0;
                #1;
                check_reset_vals({tag, "_midrst"});
                return;
            end
            start = (idx == stray_at);
            if (sram_cena !== (idx > T_LASTR)) cena_err++;
            if (idx <= T_LASTR && sram_aa !== 16'(src_addr(idx / 4, idx % 4))) aa_err++;
            if (busy !== (idx < T_DONE) || done !== (idx >= T_DONE)) bd_err++;
            if (done === 1'b1 && done_idx < 0) done_idx = idx;
            if (sram_cenb === 1'b0) begin
                if (sram_wenb !== 1'b0) pb_err++;
                if (idx != 4 * wr_seen + 5) wt_err++;
                if (sram_ab < DST || sram_ab >= DST + NW) rg_err++;
                if (exp_q.size() == 0) extra++;
                else begin
                    e = exp_q.pop_front();
                    chk($sformatf("%s_sb_w%0d", tag, wr_seen), {sram_ab, sram_db}, {e.addr, e.data});
                end
                wr_seen++;
            end else if (sram_wenb !== 1'b1) pb_err++;
        end
        start = 1'b0;
        chk({tag, "_done_cycle"}, done_idx, T_DONE);
        chk({tag, "_write_count"}, wr_seen, NW);
        chk({tag, "_sb_left"}, exp_q.size(), 0);
        chk({tag, "_sb_extra"}, extra, 0);
        chk({tag, "_cena_rule"}, cena_err, 0);
        chk({tag, "_aa_seq"}, aa_err, 0);
        chk({tag, "_busy_done"}, bd_err, 0);
        chk({tag, "_portb_rule"}, pb_err, 0);
        chk({tag, "_write_timing"}, wt_err, 0);
        chk({tag, "_write_range"}, rg_err, 0);
        @(posedge clk); #1;
        for (int i = 0; i < NSRC; i++) if (mem[i] !== img[i]) diffs++;
        chk({tag, "_src_intact"}, diffs, 0);
        diffs = 0;
        for (int w = 0; w < NW; w++) if (mem[DST + w] !== exp_img[w]) diffs++;
        chk({tag, "_dst_image"}, diffs, 0);
    endtask

    initial begin
        total = 0;
        bad = 0;
        tbl[0] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'h80000000, 32'hFFFFFFF0, 32'hFFFFFFFF};
        tbl[1] = '{32'hFFFFFFFF, 32'h00000001, 32'h80000000, 32'hFFFFFFF0, 32'h00000001};
        tbl[2] = '{32'd7, 32'd0, 32'd0, 32'd0, 32'd7};
        tbl[3] = '{32'd0, 32'd7, 32'd0, 32'd0, 32'd7};
        tbl[4] = '{32'd0, 32'd0, 32'd7, 32'd0, 32'd7};
        tbl[5] = '{32'd0, 32'd0, 32'd0, 32'd7, 32'd7};
        tbl[6] = '{32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000};
        tbl[7] = '{32'h7FFFFFFF, 32'h80000000, 32'h00000000, 32'hFFFFFFFF, 32'h7FFFFFFF};
        tbl[8] = '{32'd5, 32'd5, 32'd5, 32'd5, 32'd5};
        tbl[9] = '{32'h80000000, 32'h80000001, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF};

        #12;
        check_reset_vals("por");
        @(posedge clk); #1 rst = 1'b1;

        prep_ramp();  load_mem(); push_exp(); run_pass("ramp", -1, -1);
        prep_table(); load_mem(); push_exp(); run_pass("table", 100, -1);
        prep_rand();  load_mem(); push_exp(); run_pass("rand_rst", -1, 2000);

        chk("partial_kept", mem[DST], exp_img[0]);
        @(posedge clk); #1 rst = 1'b1;
        push_exp(); run_pass("restart", -1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
